// File: rtl/spi_master_driver.sv
// rtl/spi_master_driver.sv - full-duplex SPI master, one byte per tx handshake, all four SPI modes
module spi_master_driver #(
  parameter logic [1:0] MODE    = 2'b00,
  parameter int         CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  localparam logic        CPOL   = MODE[1];
  localparam logic        CPHA   = MODE[0];
  localparam logic [15:0] DIV_TC = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_WAIT, S_HOLD} state_t;

  state_t      state_q;
  logic [15:0] div_q;
  logic [3:0]  edge_q;
  logic [7:0]  tx_sr_q;
  logic [7:0]  rx_sr_q;
  logic [7:0]  rx_data_q;
  logic        last_q;
  logic        sclk_q;
  logic        mosi_q;
  logic        cs_n_q;
  logic        rx_valid_q;

  logic       accept;
  logic       div_tc;
  logic       leading;
  logic       sample_now;
  logic       drive_now;
  logic [7:0] rx_shift;

  always_comb begin
    tx_ready   = (state_q == S_IDLE) || (state_q == S_WAIT);
    accept     = tx_valid && tx_ready;
    div_tc     = (div_q == DIV_TC);
    // Edges are counted from zero, so an even count means the next edge is a leading one.
    leading    = ~edge_q[0];
    sample_now = (state_q == S_XFER) && div_tc && (leading ^ CPHA);
    drive_now  = (state_q == S_XFER) && div_tc && (leading == CPHA) && (edge_q != 4'd15);
    rx_shift   = {rx_sr_q[6:0], miso};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      edge_q     <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      last_q     <= 1'b0;
      sclk_q     <= CPOL;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (sample_now) rx_sr_q <= rx_shift;
      if (drive_now) begin
        mosi_q  <= tx_sr_q[7];
        tx_sr_q <= {tx_sr_q[6:0], 1'b0};
      end
      // With CPHA=0 bit7 goes out at accept, so the shifter starts one bit ahead.
      if (accept) begin
        tx_sr_q <= CPHA ? tx_data : {tx_data[6:0], 1'b0};
        last_q  <= tx_last;
        if (!CPHA) mosi_q <= tx_data[7];
        cs_n_q  <= 1'b0;
        div_q   <= '0;
        edge_q  <= '0;
        state_q <= (state_q == S_IDLE) ? S_SETUP : S_XFER;
      end else begin
        case (state_q)
          S_SETUP: begin
            if (div_tc) begin
              div_q   <= '0;
              state_q <= S_XFER;
            end else begin
              div_q <= div_q + 16'd1;
            end
          end
          S_XFER: begin
            if (div_tc) begin
              div_q  <= '0;
              sclk_q <= ~sclk_q;
              edge_q <= edge_q + 4'd1;
              if (edge_q == 4'd15) begin
                rx_data_q  <= sample_now ? rx_shift : rx_sr_q;
                rx_valid_q <= 1'b1;
                state_q    <= last_q ? S_HOLD : S_WAIT;
              end
            end else begin
              div_q <= div_q + 16'd1;
            end
          end
          S_HOLD: begin
            if (div_tc) begin
              div_q   <= '0;
              cs_n_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              div_q <= div_q + 16'd1;
            end
          end
          S_IDLE, S_WAIT: begin
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master_driver.sv
// tb/tb_spi_master_driver.sv - directed bench: modes 00/01/10/11 at CLK_DIV=4 plus mode 00 at CLK_DIV=2
module tb_spi_master_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic [4:0] tx_valid_v = 5'b0;
  logic [4:0] tx_ready_v, rx_valid_v, busy_v, sclk_v, mosi_v, miso_v, cs_n_v;
  logic [7:0] rx_data_v [5];

  // Instances 0..3: MODE 00/01/10/11 at CLK_DIV=4; instance 4: MODE 00 at CLK_DIV=2.
  for (genvar g = 0; g < 5; g++) begin : g_dut
    spi_master_driver #(.MODE(2'(g % 4)), .CLK_DIV((g == 4) ? 2 : 4)) u_dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_last(tx_last),
      .tx_valid(tx_valid_v[g]), .tx_ready(tx_ready_v[g]),
      .rx_data(rx_data_v[g]), .rx_valid(rx_valid_v[g]), .busy(busy_v[g]),
      .sclk(sclk_v[g]), .mosi(mosi_v[g]), .miso(miso_v[g]), .cs_n(cs_n_v[g]));
  end

  // Mode-0 slave model attached to instance sel: shifts s_byte out, captures mosi bytes.
  logic       loopback = 1'b0;
  logic [2:0] sel = 3'd0;
  logic [7:0] s_byte = 8'h3C;
  logic [2:0] s_idx = 3'd0;
  logic [2:0] s_cnt = 3'd0;
  logic [7:0] s_rx = 8'h00;
  logic       s_sclk_d = 1'b0;
  logic       s_sclk, s_cs_n, s_mosi;
  logic [7:0] rec_q [$];

  assign s_sclk = sclk_v[sel];
  assign s_cs_n = cs_n_v[sel];
  assign s_mosi = mosi_v[sel];
  assign miso_v[0] = loopback ? mosi_v[0] : s_byte[~s_idx];
  assign miso_v[1] = mosi_v[1];
  assign miso_v[2] = mosi_v[2];
  assign miso_v[3] = mosi_v[3];
  assign miso_v[4] = loopback ? mosi_v[4] : s_byte[~s_idx];

  always @(posedge clk) begin
    s_sclk_d <= s_sclk;
    if (s_cs_n) begin
      s_idx <= 3'd0;
      s_cnt <= 3'd0;
    end else begin
      if (!s_sclk_d && s_sclk) begin
        s_rx  <= {s_rx[6:0], s_mosi};
        s_cnt <= s_cnt + 3'd1;
        if (s_cnt == 3'd7) rec_q.push_back({s_rx[6:0], s_mosi});
      end
      if (s_sclk_d && !s_sclk) s_idx <= s_idx + 3'd1;
    end
  end

  int rxv_cnt = 0;
  int csl_cnt = 0;
  always @(negedge clk) begin
    if (rx_valid_v[0]) rxv_cnt <= rxv_cnt + 1;
    if (!cs_n_v[0])    csl_cnt <= csl_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_check(input string tag, input logic [7:0] exp);
    logic [31:0] got;
    got = (rec_q.size() > 0) ? {24'd0, rec_q.pop_front()} : 32'hDEAD;
    check(tag, got, {24'd0, exp});
  endtask

  task automatic accept(input logic [4:0] mask, input logic [7:0] d, input logic last);
    @(negedge clk);
    check("ready_before_accept", tx_ready_v & mask, mask);
    tx_data    = d;
    tx_last    = last;
    tx_valid_v = mask;
    @(posedge clk);
    #1;
    tx_valid_v = 5'b0;
  endtask

  task automatic wait_idle(input logic [4:0] mask);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((busy_v & mask) != 5'b0) && n < 2000);
    check("idle_timeout", busy_v & mask, 5'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, m, e, bad, rxv0, csl0, first, last_t, edges, rxv_t;
    logic prev;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n_v, 5'b11111);
    check("rst_sclk", sclk_v, 5'b01100);
    check("rst_mosi", mosi_v, 5'b0);
    check("rst_busy", busy_v, 5'b0);
    check("rst_rx_valid", rx_valid_v, 5'b0);
    check("rst_rx_data0", rx_data_v[0], 8'h00);
    rst = 1'b0;

    // Mode 00 single byte, timing of first edge, rx_valid and cs_n window
    rxv0 = rxv_cnt; csl0 = csl_cnt;
    accept(5'b00001, 8'hA5, 1'b1);
    n = 0;
    @(negedge clk);
    check("cs_low_next", cs_n_v[0], 1'b0);
    check("busy_setup", busy_v[0], 1'b1);
    while (!sclk_v[0] && n < 100) begin @(negedge clk); n++; end
    check("first_edge_time", n, 8);
    while (!rx_valid_v[0] && n < 200) begin @(negedge clk); n++; end
    check("rx_valid_time", n, 68);
    check("rx_data_a5", rx_data_v[0], 8'h3C);
    while (busy_v[0] && n < 300) begin @(negedge clk); n++; end
    check("idle_time", n, 72);
    check("cs_high_after", cs_n_v[0], 1'b1);
    check("sclk_idle_after", sclk_v[0], 1'b0);
    @(negedge clk); #1;
    check("rx_valid_once", rxv_cnt - rxv0, 1);
    check("cs_low_cycles", csl_cnt - csl0, 72);
    slave_check("slave_rx_a5", 8'hA5);

    // Loopback in all four modes
    loopback = 1'b1;
    check("sclk_idle_pre", sclk_v[3:0], 4'b1100);
    accept(5'b01111, 8'h96, 1'b1);
    wait_idle(5'b01111);
    for (int i = 0; i < 4; i++) check($sformatf("loop_mode%0d", i), rx_data_v[i], 8'h96);
    check("sclk_idle_post", sclk_v[3:0], 4'b1100);
    slave_check("slave_rx_96", 8'h96);
    loopback = 1'b0;

    // Three-byte burst with tx_valid held high
    @(negedge clk); #1;
    rxv0 = rxv_cnt; csl0 = csl_cnt;
    @(negedge clk);
    tx_data = 8'h01; tx_last = 1'b0; tx_valid_v = 5'b00001;
    @(posedge clk); #1;
    tx_data = 8'h02;
    n = 0;
    @(negedge clk);
    while (!tx_ready_v[0] && n < 200) begin @(negedge clk); n++; end
    check("burst_wait1_time", n, 68);
    check("rxv_with_ready", rx_valid_v[0], 1'b1);
    @(posedge clk); #1;
    tx_data = 8'h03; tx_last = 1'b1;
    m = 0;
    @(negedge clk);
    while (!tx_ready_v[0] && m < 200) begin @(negedge clk); m++; end
    check("b2b_period", m + 1, 65);
    @(posedge clk); #1;
    tx_valid_v = 5'b0;
    wait_idle(5'b00001);
    @(negedge clk); #1;
    check("burst_rx_valid_cnt", rxv_cnt - rxv0, 3);
    check("burst_cs_low_cycles", csl_cnt - csl0, 202);
    slave_check("burst_slave_b1", 8'h01);
    slave_check("burst_slave_b2", 8'h02);
    slave_check("burst_slave_b3", 8'h03);

    // WAIT stall of 50 cycles between bytes
    accept(5'b00001, 8'h55, 1'b0);
    n = 0;
    while (!tx_ready_v[0] && n < 200) begin @(negedge clk); n++; end
    check("stall_reach_wait", tx_ready_v[0], 1'b1);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (cs_n_v[0] || sclk_v[0] || !busy_v[0] || !tx_ready_v[0]) bad++;
    end
    check("stall_hold", bad, 0);
    accept(5'b00001, 8'hAA, 1'b1);
    wait_idle(5'b00001);
    slave_check("stall_slave_55", 8'h55);
    slave_check("stall_slave_aa", 8'hAA);
    check("stall_rx_data", rx_data_v[0], 8'h3C);

    // Reset after the 7th sclk edge
    @(negedge clk); #1;
    rxv0 = rxv_cnt;
    accept(5'b00001, 8'h11, 1'b1);
    e = 0; n = 0; prev = sclk_v[0];
    while (e < 7 && n < 200) begin
      @(negedge clk); n++;
      if (sclk_v[0] != prev) begin e++; prev = sclk_v[0]; end
    end
    #1 rst = 1'b1;
    #1;
    check("midrst_cs_n", cs_n_v[0], 1'b1);
    check("midrst_sclk", sclk_v[0], 1'b0);
    check("midrst_busy", busy_v[0], 1'b0);
    check("midrst_rx_data", rx_data_v[0], 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("midrst_no_rx_valid", rxv_cnt - rxv0, 0);
    check("midrst_slave_empty", rec_q.size(), 0);
    accept(5'b00001, 8'hF0, 1'b1);
    wait_idle(5'b00001);
    slave_check("after_rst_slave_f0", 8'hF0);
    check("after_rst_rx_data", rx_data_v[0], 8'h3C);

    // CLK_DIV=2 boundary on instance 4
    @(negedge clk);
    sel = 3'd4;
    repeat (2) @(negedge clk);
    accept(5'b10000, 8'hC3, 1'b1);
    n = 0; prev = sclk_v[4]; first = -1; last_t = -1; edges = 0; rxv_t = -1; bad = 0;
    @(negedge clk);
    while (busy_v[4] && n < 500) begin
      if (sclk_v[4] != prev) begin
        if (first < 0) first = n;
        else if (n - last_t != 2) bad++;
        last_t = n; prev = sclk_v[4]; edges++;
      end
      if (rx_valid_v[4]) rxv_t = n;
      @(negedge clk); n++;
    end
    check("div2_first_edge", first, 4);
    check("div2_level_len", bad, 0);
    check("div2_edges", edges, 16);
    check("div2_rx_valid_time", rxv_t, 34);
    check("div2_rx_data", rx_data_v[4], 8'h3C);
    slave_check("div2_slave_c3", 8'hC3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
